// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider core among CLIENTS requesters.
// A zero divisor is answered locally (all-ones quotient, remainder = dividend) without using the core.
module div_arbiter #(
  parameter int WIDTH   = 8,
  parameter int CLIENTS = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [CLIENTS-1:0]         cl_req,
  input  logic [CLIENTS*WIDTH-1:0]   cl_dividend,
  input  logic [CLIENTS*WIDTH-1:0]   cl_divisor,
  output logic [CLIENTS-1:0]         cl_ack,
  output logic [WIDTH-1:0]           cl_quotient,
  output logic [WIDTH-1:0]           cl_remainder,
  output logic                       busy,
  output logic                       div_req,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic                       div_ack,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder
);

  // states: IDLE arbitrate | ISSUE div_req pulse | WAIT core running | RESP cl_ack pulse
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int            IW   = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam logic [IW:0]   NCL  = (IW+1)'(CLIENTS);
  localparam logic [IW-1:0] LAST = IW'(CLIENTS - 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     sum;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] pick_dvd;
  logic [WIDTH-1:0] pick_dvs;

  // Search starts at ptr and wraps; the first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= NCL) sum = sum - NCL;
      idx = sum[IW-1:0];
      if (!found && cl_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    pick_dvd = '0;
    pick_dvs = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      if (pick == IW'(k)) begin
        pick_dvd = cl_dividend[k*WIDTH +: WIDTH];
        pick_dvs = cl_divisor[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt          <= '0;
      busy         <= 1'b0;
      div_req      <= 1'b0;
      cl_ack       <= '0;
      cl_quotient  <= '0;
      cl_remainder <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      div_req <= 1'b0;
      cl_ack  <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt  <= pick;
            busy <= 1'b1;
            if (pick_dvs != '0) begin
              div_dividend <= pick_dvd;
              div_divisor  <= pick_dvs;
              div_req      <= 1'b1;
              state        <= ISSUE;
            end else begin
              cl_quotient  <= '1;
              cl_remainder <= pick_dvd;
              cl_ack[pick] <= 1'b1;
              state        <= RESP;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (div_ack) begin
            cl_quotient  <= div_quotient;
            cl_remainder <= div_remainder;
            cl_ack[gnt]  <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          ptr   <= (gnt == LAST) ? '0 : gnt + IW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioral divider core, result scoreboard checked on every cl_ack.
module tb_div_arbiter;
  localparam int W  = 8;
  localparam int N  = 2;
  localparam int CW = 1;
  typedef logic [CW-1:0] cid_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     cl_req = '0;
  logic [N*W-1:0]   cl_dividend = '0;
  logic [N*W-1:0]   cl_divisor = '0;
  logic [N-1:0]     cl_ack;
  logic [W-1:0]     cl_quotient, cl_remainder;
  logic             busy, div_req;
  logic [W-1:0]     div_dividend, div_divisor;
  logic             div_ack;
  logic [W-1:0]     div_quotient, div_remainder;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_pulses = 0;

  typedef struct {
    cid_t       client;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;
  exp_t sb[$];

  div_arbiter #(.WIDTH(W), .CLIENTS(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .cl_req(cl_req), .cl_dividend(cl_dividend), .cl_divisor(cl_divisor),
    .cl_ack(cl_ack), .cl_quotient(cl_quotient), .cl_remainder(cl_remainder),
    .busy(busy), .div_req(div_req), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ack(div_ack), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // divider core: starts at the edge ending the div_req cycle c, acks in cycle c+W+2
  logic         core_busy;
  int           core_cnt;
  logic [W-1:0] core_a, core_b;
  always @(posedge clk) begin
    if (!reset_n) begin
      core_busy     <= 1'b0;
      core_cnt      <= 0;
      div_ack       <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      div_ack <= 1'b0;
      if (div_req) req_pulses <= req_pulses + 1;
      if (core_busy) begin
        total++;
        if (div_req) begin
          bad++;
          $display("FAIL div_req_overlap: div_req=%b while core busy, required 0", div_req);
        end
        if (core_cnt == 0) begin
          div_ack       <= 1'b1;
          div_quotient  <= (core_b == 0) ? '1 : core_a / core_b;
          div_remainder <= (core_b == 0) ? core_a : core_a % core_b;
          core_busy     <= 1'b0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end else if (div_req) begin
        core_busy <= 1'b1;
        core_cnt  <= W;
        core_a    <= div_dividend;
        core_b    <= div_divisor;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [N-1:0] want;
    if (reset_n && cl_ack != '0) begin
      total++;
      if ($countones(cl_ack) != 1) begin
        bad++;
        $display("FAIL ack_onehot: cl_ack=%b, required one-hot", cl_ack);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: cl_ack=%b with no job expected", cl_ack);
      end else begin
        e = sb.pop_front();
        want = '0;
        want[e.client] = 1'b1;
        if (cl_ack !== want || cl_quotient !== e.q || cl_remainder !== e.r) begin
          bad++;
          $display("FAIL result: ack=%b q=%0d r=%0d, required ack=%b q=%0d r=%0d",
                   cl_ack, cl_quotient, cl_remainder, want, e.q, e.r);
        end
      end
    end
  end

  task automatic set_ops(input cid_t c, input logic [W-1:0] a, input logic [W-1:0] b);
    if (c == 1'b0) begin
      cl_dividend[0 +: W] = a;
      cl_divisor[0 +: W]  = b;
    end else begin
      cl_dividend[W +: W] = a;
      cl_divisor[W +: W]  = b;
    end
  endtask

  task automatic push_exp(input cid_t c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.client = c;
    e.q = (b == 0) ? '1 : a / b;
    e.r = (b == 0) ? a : a % b;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input cid_t c, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cl_ack[c]) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Called #1 after a posedge with the arbiter idle; returns #1 after a posedge.
  task automatic do_job(input cid_t c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input string name);
    int t, at;
    push_exp(c, a, b);
    set_ops(c, a, b);
    cl_req[c] = 1'b1;
    t = cyc;
    wait_ack(c, 40, at);
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL %s_timeout: no cl_ack within 40 cycles", name);
    end else begin
      if (at - t != exp_lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, at - t, exp_lat);
      end
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_busy_resp: busy=%b in ack cycle, required 1", name, busy);
      end
    end
    @(posedge clk);
    #1;
    cl_req[c] = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_after: busy=%b after RESP, required 0", name, busy);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    total++;
    if ({cl_ack, div_req, busy, cl_quotient, cl_remainder, div_dividend, div_divisor} !== '0) begin
      bad++;
      $display("FAIL %s: ack=%b req=%b busy=%b q=%0d r=%0d dd=%0d dv=%0d, required all 0",
               name, cl_ack, div_req, busy, cl_quotient, cl_remainder, div_dividend, div_divisor);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int p0;
    p0 = req_pulses;
    do_job(1'b0, 8'd200, 8'd7, 12, "single");
    total++;
    if (req_pulses - p0 != 1) begin
      bad++;
      $display("FAIL single_req_count: got %0d div_req pulses, required 1", req_pulses - p0);
    end
  endtask

  task automatic test_zero_div();
    int p0;
    p0 = req_pulses;
    do_job(1'b1, 8'd77, 8'd0, 1, "zero_div");
    total++;
    if (req_pulses != p0) begin
      bad++;
      $display("FAIL zero_div_no_req: got %0d div_req pulses, required 0", req_pulses - p0);
    end
  endtask

  task automatic test_round_robin();
    int acks;
    int last;
    acks = 0;
    last = -1;
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 8'd100, 8'd10);
      push_exp(1'b1, 8'd255, 8'd16);
    end
    set_ops(1'b0, 8'd100, 8'd10);
    set_ops(1'b1, 8'd255, 8'd16);
    cl_req = 2'b11;
    for (int i = 0; i < 80 && acks < 4; i++) begin
      @(negedge clk);
      if (cl_ack != '0) begin
        acks++;
        if (last >= 0) begin
          total++;
          if (cyc - last != W + 5) begin
            bad++;
            $display("FAIL rr_spacing: acks %0d cycles apart, required %0d", cyc - last, W + 5);
          end
        end
        last = cyc;
      end
    end
    @(posedge clk);
    #1;
    cl_req = '0;
    total++;
    if (acks != 4) begin
      bad++;
      $display("FAIL rr_ack_count: got %0d acks, required 4", acks);
    end
  endtask

  task automatic test_operand_change();
    int t, at;
    push_exp(1'b0, 8'd50, 8'd3);
    set_ops(1'b0, 8'd50, 8'd3);
    cl_req[0] = 1'b1;
    t = cyc;
    repeat (2) @(posedge clk);
    #1;
    set_ops(1'b0, 8'd9, 8'd9);
    @(negedge clk);
    total++;
    if (div_dividend !== 8'd50 || div_divisor !== 8'd3) begin
      bad++;
      $display("FAIL opchg_core_ops: got %0d/%0d, required 50/3", div_dividend, div_divisor);
    end
    wait_ack(1'b0, 40, at);
    total++;
    if (at < 0 || at - t != 12) begin
      bad++;
      $display("FAIL opchg_latency: got %0d, required 12", (at < 0) ? -1 : at - t);
    end
    @(posedge clk);
    #1;
    cl_req[0] = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int seen;
    seen = 0;
    set_ops(1'b0, 8'd100, 8'd3);
    cl_req[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    cl_req = '0;
    @(posedge clk);
    #1;
    check_zero_outputs("midjob_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cl_ack != '0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midjob_no_ack: got %0d acks after reset, required 0", seen);
    end
    @(posedge clk);
    #1;
    do_job(1'b0, 8'd12, 8'd5, 12, "after_reset");
  endtask

  task automatic test_edge_operands();
    do_job(1'b0, 8'd255, 8'd1, 12, "edge_255_1");
    do_job(1'b1, 8'd0, 8'd200, 12, "edge_0_200");
    do_job(1'b0, 8'd5, 8'd9, 12, "edge_5_9");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_zero_div();
    test_round_robin();
    test_operand_change();
    test_reset_mid_job();
    test_edge_operands();
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_empty: %0d expected acks never seen, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
